csr_exec_unit: RTL and testbench

//  Execute-stage sequencer for Zicsr instructions (CSRRW/S/C and immediate forms), directly upstream of the CSR file.

---
 rtl/csr_exec_if.sv | 43 ++++
 rtl/csr_exec_unit.sv | 150 +++++++++++++++
 tb/tb_csr_exec_unit.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_exec_if.sv
// Bundle between the CSR execute sequencer and its neighbours: decode issue,
// CSR-file strobes and writeback result handshake.
interface csr_exec_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  funct3;
  logic [11:0] csr_num;
  logic [31:0] rs1_value;
  logic [4:0]  rs1_zimm;
  logic [4:0]  rd_index;

  logic [11:0] csr_num_out;
  logic        read_csr;
  logic        write_csr;
  logic [2:0]  write_function;
  logic [31:0] write_value;
  logic [31:0] csr_read_value;
  logic        csr_illegal;

  logic        result_valid;
  logic        result_ready;
  logic [4:0]  rd_index_out;
  logic [31:0] rd_value;
  logic        rd_write_enable;
  logic        exception;
  logic        instr_retired;

  modport master (
    output instr_valid, funct3, csr_num, rs1_value, rs1_zimm, rd_index,
           csr_read_value, csr_illegal, result_ready,
    input  instr_ready, csr_num_out, read_csr, write_csr, write_function,
           write_value, result_valid, rd_index_out, rd_value,
           rd_write_enable, exception, instr_retired
  );

  modport slave (
    input  instr_valid, funct3, csr_num, rs1_value, rs1_zimm, rd_index,
           csr_read_value, csr_illegal, result_ready,
    output instr_ready, csr_num_out, read_csr, write_csr, write_function,
           write_value, result_valid, rd_index_out, rd_value,
           rd_write_enable, exception, instr_retired
  );
endinterface

// File: rtl/csr_exec_unit.sv
// Zicsr execute sequencer: latches one CSR op, strobes the CSR file for the
// read and/or write it needs, and hands the old value back to writeback.
module csr_exec_unit #(
  parameter logic [1:0] PRIV_LEVEL = 2'b11
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       flush_i,
  csr_exec_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [11:0] csr_q, csr_d;
  logic [31:0] src_q, src_d;
  logic [31:0] old_q, old_d;
  logic [4:0]  rd_q, rd_d;
  logic        exc_q, exc_d;
  logic        no_read_q, no_read_d;
  logic        no_write_q, no_write_d;

  logic        accept;
  logic        rd_strobe, wr_strobe;
  logic [31:0] in_src;
  logic        in_rw, in_no_read, in_no_write;
  logic [2:0]  priv_diff;
  logic        in_illegal;
  logic        resp;

  function automatic logic [31:0] csr_new_value(input logic [1:0]  kind,
                                                input logic [31:0] old,
                                                input logic [31:0] src);
    case (kind)
      2'b01:   csr_new_value = src;
      2'b10:   csr_new_value = old | src;
      default: csr_new_value = old & ~src;
    endcase
  endfunction

  assign in_src      = bus.funct3[2] ? {27'b0, bus.rs1_zimm} : bus.rs1_value;
  assign in_rw       = (bus.funct3[1:0] == 2'b01);
  assign in_no_read  = in_rw && (bus.rd_index == 5'd0);
  assign in_no_write = !in_rw && (bus.rs1_zimm == 5'd0);
  // Borrow out of PRIV_LEVEL - csr_num[9:8] means the CSR needs more privilege.
  assign priv_diff   = {1'b0, PRIV_LEVEL} - {1'b0, bus.csr_num[9:8]};
  assign in_illegal  = (bus.funct3[1:0] == 2'b00) || priv_diff[2] ||
                       (!in_no_write && (bus.csr_num[11:10] == 2'b11));

  assign bus.instr_ready = (state_q == S_IDLE) && !flush_i;
  assign accept          = bus.instr_valid && bus.instr_ready;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      funct3_q   <= 3'd0;
      csr_q      <= 12'd0;
      src_q      <= 32'd0;
      old_q      <= 32'd0;
      rd_q       <= 5'd0;
      exc_q      <= 1'b0;
      no_read_q  <= 1'b0;
      no_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      funct3_q   <= funct3_d;
      csr_q      <= csr_d;
      src_q      <= src_d;
      old_q      <= old_d;
      rd_q       <= rd_d;
      exc_q      <= exc_d;
      no_read_q  <= no_read_d;
      no_write_q <= no_write_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    funct3_d   = funct3_q;
    csr_d      = csr_q;
    src_d      = src_q;
    old_d      = old_q;
    rd_d       = rd_q;
    exc_d      = exc_q;
    no_read_d  = no_read_q;
    no_write_d = no_write_q;
    rd_strobe  = 1'b0;
    wr_strobe  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          funct3_d   = bus.funct3;
          csr_d      = bus.csr_num;
          src_d      = in_src;
          old_d      = 32'd0;
          rd_d       = bus.rd_index;
          exc_d      = in_illegal;
          no_read_d  = in_no_read;
          no_write_d = in_no_write;
          if (in_illegal)      state_d = S_RESP;
          else if (in_no_read) state_d = S_WRITE;
          else                 state_d = S_READ;
        end
      end
      S_READ: begin
        rd_strobe = 1'b1;
        if (bus.csr_illegal) begin
          exc_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          old_d   = bus.csr_read_value;
          state_d = no_write_q ? S_RESP : S_WRITE;
        end
      end
      S_WRITE: begin
        wr_strobe = 1'b1;
        if (bus.csr_illegal) exc_d = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A redirect kills the op outright, including a strobe already due this cycle.
    if (flush_i) begin
      state_d   = S_IDLE;
      rd_strobe = 1'b0;
      wr_strobe = 1'b0;
    end
  end

  assign resp = (state_q == S_RESP) && !flush_i && !reset_i;

  assign bus.read_csr        = rd_strobe && !reset_i;
  assign bus.write_csr       = wr_strobe && !reset_i;
  assign bus.csr_num_out     = csr_q;
  assign bus.write_function  = funct3_q;
  assign bus.write_value     = csr_new_value(funct3_q[1:0], old_q, src_q);
  assign bus.result_valid    = resp;
  assign bus.rd_index_out    = rd_q;
  assign bus.rd_value        = old_q;
  assign bus.rd_write_enable = resp && !exc_q && !no_read_q && (rd_q != 5'd0);
  assign bus.exception       = resp && exc_q;
  assign bus.instr_retired   = resp && bus.result_ready && !exc_q;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Directed bench for csr_exec_unit: a spec-level op model predicts strobe
// timing and results, checked every cycle by one compare process.
module tb_csr_exec_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  csr_exec_if bus();

  csr_exec_unit #(.PRIV_LEVEL(2'b11)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  localparam int PRIV = 3;

  // CSR file stand-in
  logic [31:0] old_v = 32'd0;
  logic        illr_v = 1'b0;
  logic        illw_v = 1'b0;
  assign bus.csr_read_value = bus.read_csr ? old_v : 32'hDEAD_BEEF;
  assign bus.csr_illegal    = (bus.read_csr & illr_v) | (bus.write_csr & illw_v);

  typedef struct {
    bit          rd;
    bit          wr;
    bit          exc;
    bit          rdwe;
    int          rk;
    logic [31:0] wval;
    logic [31:0] rval;
    logic [4:0]  rdi;
    logic [11:0] csr;
    logic [2:0]  f3;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   op_id = 0;
  int   done_id = 0;
  int   fk = 0;
  int   retire_cnt = 0;
  bit   closing = 1'b0;
  exp_t e;
  logic [31:0] last_wval = 32'd0;
  logic [31:0] last_rval = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] f3, input logic [11:0] csr,
                                 input logic [31:0] rs1, input logic [4:0] zimm,
                                 input logic [4:0] rd, input logic [31:0] old,
                                 input bit illr, input bit illw);
    exp_t m;
    logic [31:0] src, o;
    bit rw;
    src   = f3[2] ? {27'b0, zimm} : rs1;
    rw    = (f3[1:0] == 2'b01);
    m.rd  = !(rw && rd == 5'd0);
    m.wr  = !(!rw && zimm == 5'd0);
    m.exc = 1'b0;
    m.rdi = rd;
    m.csr = csr;
    m.f3  = f3;
    if (f3[1:0] == 2'b00 || (m.wr && csr[11:10] == 2'b11) || int'(csr[9:8]) > PRIV) begin
      m.exc = 1'b1; m.rd = 1'b0; m.wr = 1'b0;
    end else if (m.rd && illr) begin
      m.exc = 1'b1; m.wr = 1'b0;
    end else if (m.wr && illw) begin
      m.exc = 1'b1;
    end
    o      = m.rd ? old : 32'd0;
    m.wval = rw ? src : ((f3[1:0] == 2'b10) ? (o | src) : (o & ~src));
    m.rval = o;
    m.rdwe = !m.exc && m.rd && (rd != 5'd0);
    m.rk   = 1 + int'(m.rd) + int'(m.wr);
    return m;
  endfunction

  // Per-cycle comparison against the active op's expectation
  always @(negedge clk) begin
    int k;
    bit xr, xw, xv;
    if (op_id != done_id) begin
      k = cyc - acc_cyc;
      if (closing) begin
        chk("post_resp_valid", bus.result_valid, 0);
        chk("post_resp_ready", bus.instr_ready, 1);
        chk("post_resp_retire", bus.instr_retired, 0);
        closing = 1'b0;
        done_id = op_id;
      end else if (fk != 0 && k >= fk) begin
        if (k == fk) begin
          chk("flush_read", bus.read_csr, 0);
          chk("flush_write", bus.write_csr, 0);
          chk("flush_retire", bus.instr_retired, 0);
        end else begin
          chk("flush_idle_ready", bus.instr_ready, 1);
          chk("flush_no_result", bus.result_valid, 0);
          done_id = op_id;
        end
      end else begin
        xr = e.rd && (k == 1);
        xw = e.wr && (k == (e.rd ? 2 : 1));
        xv = (k >= e.rk);
        chk("read_csr", bus.read_csr, xr);
        chk("write_csr", bus.write_csr, xw);
        chk("result_valid", bus.result_valid, xv);
        chk("busy_ready", bus.instr_ready, 0);
        if (bus.write_csr) begin
          chk("write_value", bus.write_value, e.wval);
          chk("csr_num_out", bus.csr_num_out, e.csr);
          chk("write_function", bus.write_function, e.f3);
          last_wval = bus.write_value;
        end
        if (bus.result_valid) begin
          chk("exception", bus.exception, e.exc);
          chk("rd_write_enable", bus.rd_write_enable, e.rdwe);
          chk("rd_index_out", bus.rd_index_out, e.rdi);
          if (!e.exc) chk("rd_value", bus.rd_value, e.rval);
          chk("instr_retired", bus.instr_retired, bus.result_ready && !e.exc);
          if (bus.result_ready) begin
            closing   = 1'b1;
            last_rval = bus.rd_value;
          end
        end
      end
    end
    if (bus.instr_retired) retire_cnt++;
  end

  task automatic run_op(input logic [2:0] f3, input logic [11:0] csr,
                        input logic [31:0] rs1, input logic [4:0] zimm,
                        input logic [4:0] rd, input logic [31:0] old,
                        input bit illr, input bit illw,
                        input int hold, input int flush_k);
    exp_t m;
    int hcnt;
    int k;
    bit fin;
    m      = model(f3, csr, rs1, zimm, rd, old, illr, illw);
    old_v  = old;
    illr_v = illr;
    illw_v = illw;
    bus.funct3      = f3;
    bus.csr_num     = csr;
    bus.rs1_value   = rs1;
    bus.rs1_zimm    = zimm;
    bus.rd_index    = rd;
    bus.instr_valid = 1'b1;
    chk("accept_ready", bus.instr_ready, 1);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.funct3      = 3'b000;
    bus.csr_num     = 12'hFFF;
    bus.rs1_value   = 32'hFFFF_FFFF;
    bus.rs1_zimm    = 5'h1F;
    bus.rd_index    = 5'h1F;
    e       = m;
    fk      = flush_k;
    acc_cyc = cyc - 1;
    op_id++;
    hcnt = 0;
    fin  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (op_id == done_id) begin
        fin = 1'b1;
        break;
      end
      k = cyc - acc_cyc;
      flush = (flush_k != 0) && (k == flush_k);
      if (bus.result_valid) begin
        bus.result_ready = (hcnt >= hold);
        hcnt++;
      end else begin
        bus.result_ready = 1'b0;
      end
      @(posedge clk); #1;
    end
    if (!fin) chk("op_timeout", 0, 1);
    flush            = 1'b0;
    bus.result_ready = 1'b0;
    illr_v           = 1'b0;
    illw_v           = 1'b0;
  endtask

  initial begin
    exp_t mp;
    bus.instr_valid  = 1'b0;
    bus.funct3       = 3'd0;
    bus.csr_num      = 12'd0;
    bus.rs1_value    = 32'd0;
    bus.rs1_zimm     = 5'd0;
    bus.rd_index     = 5'd0;
    bus.result_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_instr_ready", bus.instr_ready, 1);
    chk("rst_read", bus.read_csr, 0);
    chk("rst_write", bus.write_csr, 0);
    chk("rst_result_valid", bus.result_valid, 0);
    chk("rst_retired", bus.instr_retired, 0);
    chk("rst_exception", bus.exception, 0);
    chk("rst_rdwe", bus.rd_write_enable, 0);
    chk("rst_rd_value", bus.rd_value, 0);
    chk("rst_csr_num_out", bus.csr_num_out, 0);
    chk("rst_rd_index_out", bus.rd_index_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Literal pins on the model
    mp = model(3'b010, 12'hB00, 32'h0F, 5'd1, 5'd5, 32'hF0, 0, 0);
    chk("model_rs_wval", mp.wval, 32'hFF);
    chk("model_rs_rk", mp.rk, 3);
    mp = model(3'b011, 12'h305, 32'h0F0F, 5'd2, 5'd7, 32'hFFFF, 0, 0);
    chk("model_rc_wval", mp.wval, 32'hF0F0);

    // CSRRS rd=5 rs1=0x0F, CSR 0xB00 holds 0xF0
    run_op(3'b010, 12'hB00, 32'h0F, 5'd1, 5'd5, 32'hF0, 0, 0, 0, 0);
    chk("t1_write_value", last_wval, 32'hFF);
    chk("t1_rd_value", last_rval, 32'hF0);
    // CSRRW rd=0 to 0x340: write only
    run_op(3'b001, 12'h340, 32'h1234, 5'd2, 5'd0, 32'h5555, 0, 0, 0, 0);
    chk("t2_write_value", last_wval, 32'h1234);
    // CSRRSI zimm=0 on read-only 0xC00: read only
    run_op(3'b110, 12'hC00, 32'h0, 5'd0, 5'd3, 32'hDEAD, 0, 0, 0, 0);
    chk("t3_rd_value", last_rval, 32'hDEAD);
    // CSRRW to read-only 0xC00: pre-check exception
    run_op(3'b001, 12'hC00, 32'h1, 5'd4, 5'd1, 32'h0, 0, 0, 0, 0);
    // funct3=100: pre-check exception
    run_op(3'b100, 12'h340, 32'h1, 5'd3, 5'd2, 32'h0, 0, 0, 0, 0);
    // CSRRS with CSR file flagging the read
    run_op(3'b010, 12'h300, 32'h1, 5'd1, 5'd3, 32'h77, 1, 0, 0, 0);
    // CSRRC with writeback stalled for 4 cycles
    run_op(3'b011, 12'h305, 32'h0F0F, 5'd2, 5'd7, 32'hFFFF, 0, 0, 4, 0);
    chk("t7_write_value", last_wval, 32'hF0F0);
    // CSRRCI zimm=0x1F
    run_op(3'b111, 12'h340, 32'h0, 5'h1F, 5'd2, 32'hFF, 0, 0, 0, 0);
    chk("t8_write_value", last_wval, 32'hE0);
    // CSRRWI zimm=0x15 with read
    run_op(3'b101, 12'h341, 32'h0, 5'h15, 5'd4, 32'h77, 0, 0, 1, 0);
    // CSRRW with CSR file flagging the write
    run_op(3'b001, 12'h7C0, 32'h5, 5'd1, 5'd1, 32'h9, 0, 1, 0, 0);
    // CSRRS flushed during its WRITE cycle
    run_op(3'b010, 12'hB00, 32'h0F, 5'd1, 5'd5, 32'hF0, 0, 0, 0, 2);

    // Flush in IDLE with an op presented: not accepted
    flush           = 1'b1;
    bus.funct3      = 3'b001;
    bus.csr_num     = 12'h340;
    bus.rs1_value   = 32'h1;
    bus.rs1_zimm    = 5'd1;
    bus.rd_index    = 5'd1;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    chk("idle_flush_ready", bus.instr_ready, 0);
    @(posedge clk); #1;
    flush           = 1'b0;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("idle_flush_no_read", bus.read_csr, 0);
    chk("idle_flush_no_write", bus.write_csr, 0);
    chk("idle_flush_ready_back", bus.instr_ready, 1);

    // Reset during READ drops the op
    @(posedge clk); #1;
    old_v           = 32'h12;
    bus.funct3      = 3'b010;
    bus.csr_num     = 12'h340;
    bus.rs1_zimm    = 5'd1;
    bus.rd_index    = 5'd5;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    rst             = 1'b1;
    @(negedge clk);
    chk("midrst_read", bus.read_csr, 0);
    chk("midrst_valid", bus.result_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", bus.instr_ready, 1);
    chk("midrst_write", bus.write_csr, 0);
    @(negedge clk);
    chk("midrst_write2", bus.write_csr, 0);
    chk("midrst_valid2", bus.result_valid, 0);

    chk("retire_count", retire_cnt, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
